pcie_rx_symbol_aligner: RTL
===========================

Name: pcie_rx_symbol_aligner

Overview:
Per-lane receive-side symbol aligner for the 8b/10b (Gen1/Gen2) path. It takes the serial bit stream from one electrical sub-block lane and searches for the K28.5 comma. It then acquires and maintains 10-bit symbol lock and emits aligned 10-bit symbols to the downstream 8b/10b decoder and RX elastic buffer. One instance is used per lane in the RX half of the physical layer.

Parameters:
LOCK_COMMAS, 2, number of consecutive boundary-aligned commas needed to enter LOCKED (range 1..15)
ERR_THRESH, 4, number of consecutive misaligned commas in LOCKED before lock is dropped (range 1..15)
CAND_TIMEOUT, 64, symbols allowed in CANDIDATE without a further aligned comma before returning to UNLOCKED

Ports:
clk_i  input  1  single clock; every register is in this domain
rst_i  input  1  synchronous, active-high reset
serial_bit_i  input  1  received serial bit; bit 'a' of each symbol arrives first
serial_bit_valid_i  input  1  qualifies serial_bit_i; the block holds all state when low
symbol_o  output  10  aligned symbol; [0]=a … [9]=j (jhgfiedcba ordering)
symbol_valid_o  output  1  single-cycle qualifier for symbol_o
symbol_is_comma_o  output  1  symbol_o is K28.5 of either disparity; valid only with symbol_valid_o
symbol_lock_o  output  1  high while the FSM is in LOCKED
lock_lost_o  output  1  one-cycle pulse when the FSM leaves LOCKED

Behaviour:
- Reset (synchronous, rst_i high at a clk_i edge): all outputs become 0 on that edge; the shift register, counters and FSM clear; FSM enters UNLOCKED. Reset takes priority over every other event, including in mid-symbol or in LOCKED.
- Shift register sh[9:0]. Every bit step (serial_bit_valid_i high) computes window w = {serial_bit_i, sh[9:1]}, then sets sh <= w. Oldest bit is at w[0].
- Comma hit: w == 10'h17C (K28.5 RD-) or w == 10'h283 (K28.5 RD+). Full 10-bit match.
- Phase counter bit_cnt (0..9) advances on each bit step. A boundary is a bit step with bit_cnt == 9. A comma hit on a boundary is aligned; a hit anywhere else is misaligned.
- UNLOCKED:
  - No symbols are output.
  - On any comma hit: bit_cnt <= 0, comma_cnt <= 1, go to CANDIDATE.
  - If LOCK_COMMAS == 1, the same hit goes directly to LOCKED and emits the comma.
- CANDIDATE:
  - No symbols are output. sym_cnt counts symbols since the last aligned comma.
  - Aligned comma: comma_cnt++ and sym_cnt <= 0. When comma_cnt reaches LOCK_COMMAS, go to LOCKED and emit this comma.
  - Misaligned comma: realign (bit_cnt <= 0, comma_cnt <= 1, sym_cnt <= 0) and stay in CANDIDATE.
  - sym_cnt reaching CAND_TIMEOUT: go to UNLOCKED. lock_lost_o is not pulsed.
- LOCKED:
  - On every boundary, drive symbol_o <= w and symbol_valid_o <= 1 on the next edge. Latency is one cycle after the bit step carrying bit j.
  - symbol_is_comma_o <= aligned hit.
  - Aligned comma: err_cnt <= 0.
  - Misaligned comma: err_cnt++ and the phase is left unchanged. When err_cnt reaches ERR_THRESH, go to UNLOCKED, pulse lock_lost_o for one cycle and clear err_cnt.
  - Data symbols never change err_cnt.
- symbol_valid_o is 0 in every cycle without a boundary emission, including every cycle with serial_bit_valid_i low. symbol_o holds its last value when not valid.
- Simultaneous events: a hit in UNLOCKED that is also the final bit before timeout in CANDIDATE does not arise, because the states are exclusive. In LOCKED, a bit step that is both a boundary and a hit counts as an aligned comma.
- Counters saturate at their thresholds and never wrap.

Decomposition:
- Shared package pcie_phy_pkg holds:
  - K28_5_RDN = 10'h17C and K28_5_RDP = 10'h283
  - typedef enum align_state_e {ALIGN_UNLOCKED, ALIGN_CANDIDATE, ALIGN_LOCKED}
- One sub-module, pcie_rx_comma_detect: a combinational 10-bit window compare that outputs hit and disparity. The FSM, counters and output registers stay in the top.

Test Plan:
- Reset: assert rst_i for 2 cycles with random bits present -> symbol_valid_o=0, symbol_lock_o=0, lock_lost_o=0, symbol_o=0.
- Acquire: send bits 1,0,1, then symbols 0x17C, 0x283, 0x155, 0x155 (LSB first) -> symbol_lock_o rises one cycle after the last bit of 0x283; outputs are 0x283 (comma=1), 0x155, 0x155 with no earlier valids.
- Bit slip: after lock, drop one bit, then send 5 × 0x17C -> symbol_valid_o keeps firing with garbage symbols; lock_lost_o pulses once after the 4th misaligned comma; lock is reacquired after the following 2 aligned commas.
- Candidate timeout: one 0x17C followed by 64 × 0x155 -> symbol_lock_o stays 0, no valids, FSM returns to UNLOCKED, lock_lost_o stays 0.
- Valid gaps: the acquire stream with serial_bit_valid_i randomly low 30% of cycles -> the same symbol sequence as the contiguous case, with each valid one cycle after its j bit.
- Reset mid-lock: rst_i asserted for 1 cycle while LOCKED -> all outputs 0 the next cycle; relock needs a fresh 2-comma acquisition.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared 8b/10b physical-layer definitions: K28.5 comma codes and the
// symbol aligner state encoding.
package pcie_phy_pkg;

   localparam logic [9:0] K28_5_RDN = 10'h17C;
   localparam logic [9:0] K28_5_RDP = 10'h283;

   typedef enum logic [1:0] {
      ALIGN_UNLOCKED  = 2'd0,
      ALIGN_CANDIDATE = 2'd1,
      ALIGN_LOCKED    = 2'd2
   } align_state_e;

endpackage : pcie_phy_pkg

// File: rtl/pcie_rx_comma_detect.sv
// Combinational K28.5 match over a 10-bit window (oldest bit in [0]);
// reports a hit and whether the matching code was the RD+ form.
module pcie_rx_comma_detect
   import pcie_phy_pkg::*;
(
   input  logic [9:0] window_i,
   output logic       hit_o,
   output logic       rdp_o
);

   // Full 10-bit compare against both running-disparity forms
   always_comb begin
      hit_o = 1'b0;
      rdp_o = 1'b0;
      if (window_i == K28_5_RDN) begin
         hit_o = 1'b1;
         rdp_o = 1'b0;
      end else if (window_i == K28_5_RDP) begin
         hit_o = 1'b1;
         rdp_o = 1'b1;
      end else begin
         hit_o = 1'b0;
         rdp_o = 1'b0;
      end
   end

endmodule : pcie_rx_comma_detect

// File: rtl/pcie_rx_symbol_aligner.sv
// Per-lane 8b/10b symbol aligner: hunts for K28.5 in the serial stream,
// acquires/holds 10-bit lock and emits aligned symbols while locked.
module pcie_rx_symbol_aligner
   import pcie_phy_pkg::*;
#(
   parameter int unsigned LOCK_COMMAS  = 2,
   parameter int unsigned ERR_THRESH   = 4,
   parameter int unsigned CAND_TIMEOUT = 64
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       serial_bit_i,
   input  logic       serial_bit_valid_i,
   output logic [9:0] symbol_o,
   output logic       symbol_valid_o,
   output logic       symbol_is_comma_o,
   output logic       symbol_lock_o,
   output logic       lock_lost_o
);

   localparam int unsigned SYM_CNT_W = $clog2(CAND_TIMEOUT + 1);
   localparam logic [3:0] LOCK_LAST = 4'(LOCK_COMMAS - 1);
   localparam logic [3:0] ERR_LAST  = 4'(ERR_THRESH - 1);
   localparam logic [SYM_CNT_W-1:0] SYM_LAST = SYM_CNT_W'(CAND_TIMEOUT - 1);
   localparam logic [SYM_CNT_W-1:0] SYM_ONE  = SYM_CNT_W'(1);
   localparam logic [SYM_CNT_W-1:0] SYM_ZERO = SYM_CNT_W'(0);

   logic [9:0]           sh_r;
   logic [3:0]           bit_cnt_r;
   logic [3:0]           comma_cnt_r;
   logic [3:0]           err_cnt_r;
   logic [SYM_CNT_W-1:0] sym_cnt_r;
   align_state_e         state_r;

   logic [9:0] window_s;
   logic       hit_s;
   logic       unused_rdp_s;
   logic       boundary_s;
   logic       aligned_s;

   assign window_s   = {serial_bit_i, sh_r[9:1]};
   assign boundary_s = (bit_cnt_r == 4'd9);
   assign aligned_s  = boundary_s && hit_s;

   pcie_rx_comma_detect u_comma_detect (
      .window_i (window_s),
      .hit_o    (hit_s),
      .rdp_o    (unused_rdp_s)
   );

   // Alignment FSM, phase/comma/error counters and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sh_r              <= 10'd0;
         bit_cnt_r         <= 4'd0;
         comma_cnt_r       <= 4'd0;
         err_cnt_r         <= 4'd0;
         sym_cnt_r         <= SYM_ZERO;
         state_r           <= ALIGN_UNLOCKED;
         symbol_o          <= 10'd0;
         symbol_valid_o    <= 1'b0;
         symbol_is_comma_o <= 1'b0;
         symbol_lock_o     <= 1'b0;
         lock_lost_o       <= 1'b0;
      end else begin
         symbol_valid_o <= 1'b0;
         lock_lost_o    <= 1'b0;
         if (serial_bit_valid_i) begin
            sh_r      <= window_s;
            bit_cnt_r <= boundary_s ? 4'd0 : bit_cnt_r + 4'd1;
            case (state_r)
               ALIGN_UNLOCKED: begin
                  if (hit_s) begin
                     bit_cnt_r   <= 4'd0;
                     comma_cnt_r <= 4'd1;
                     sym_cnt_r   <= SYM_ZERO;
                     err_cnt_r   <= 4'd0;
                     if (LOCK_COMMAS <= 32'd1) begin
                        state_r           <= ALIGN_LOCKED;
                        symbol_lock_o     <= 1'b1;
                        symbol_o          <= window_s;
                        symbol_valid_o    <= 1'b1;
                        symbol_is_comma_o <= 1'b1;
                     end else begin
                        state_r <= ALIGN_CANDIDATE;
                     end
                  end
               end
               ALIGN_CANDIDATE: begin
                  if (aligned_s) begin
                     sym_cnt_r <= SYM_ZERO;
                     if (comma_cnt_r >= LOCK_LAST) begin
                        state_r           <= ALIGN_LOCKED;
                        symbol_lock_o     <= 1'b1;
                        err_cnt_r         <= 4'd0;
                        symbol_o          <= window_s;
                        symbol_valid_o    <= 1'b1;
                        symbol_is_comma_o <= 1'b1;
                     end else begin
                        comma_cnt_r <= comma_cnt_r + 4'd1;
                     end
                  end else if (hit_s) begin
                     // Comma off the expected phase: restart acquisition on it
                     bit_cnt_r   <= 4'd0;
                     comma_cnt_r <= 4'd1;
                     sym_cnt_r   <= SYM_ZERO;
                  end else if (boundary_s) begin
                     if (sym_cnt_r >= SYM_LAST) begin
                        state_r <= ALIGN_UNLOCKED;
                     end else begin
                        sym_cnt_r <= sym_cnt_r + SYM_ONE;
                     end
                  end
               end
               ALIGN_LOCKED: begin
                  if (boundary_s) begin
                     symbol_o          <= window_s;
                     symbol_valid_o    <= 1'b1;
                     symbol_is_comma_o <= hit_s;
                  end
                  if (aligned_s) begin
                     err_cnt_r <= 4'd0;
                  end else if (hit_s) begin
                     if (err_cnt_r >= ERR_LAST) begin
                        state_r       <= ALIGN_UNLOCKED;
                        symbol_lock_o <= 1'b0;
                        lock_lost_o   <= 1'b1;
                        err_cnt_r     <= 4'd0;
                     end else begin
                        err_cnt_r <= err_cnt_r + 4'd1;
                     end
                  end
               end
               default: begin
                  state_r       <= ALIGN_UNLOCKED;
                  symbol_lock_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule : pcie_rx_symbol_aligner
